seg7_capture: RTL
=================

# seg7_capture

Capture port for the processor's seven-segment output: the receiving end of the digit stream the core drives onto `uo_out[6:0]`. It synchronises the segment bus and waits for each pattern to settle, because the asynchronous core produces glitches. Each settled pattern is decoded back to a hex nibble and queued in a small FIFO behind a valid/ready interface. Intended for on-chip self-test and for host readback, replacing visual inspection of the display.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: consecutive identical synchronised samples required before a pattern is accepted (≥2).
- `FIFO_DEPTH`, 4: queue entries (power of 2, ≥2).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `seg_in`  in  7  segment bus; bit0=a … bit6=g, active-high; asynchronous to `clk`.
- `clr`  in  1  synchronous clear of `overflow` and `digit_count`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  5  head entry `{err, nibble[3:0]}`.
- `overflow`  out  1  sticky; an accepted digit was dropped because the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.
- `digit_count`  out  8  count of accepted non-blank patterns; wraps modulo 256.

## Operation
- **Synchroniser:** two flops, `seg_in` → `s1` → `s`. Reset value 0.
- **Stability filter:** registers `cand[6:0]` and `cnt` (saturating at `STABLE_CYCLES`).
  - If `s != cand`: `cand <= s`, `cnt <= 0`.
  - Else if `cnt < STABLE_CYCLES`: `cnt <= cnt+1`.
  - Commit event: `s == cand` and `cnt == STABLE_CYCLES-1`. It fires exactly once per stable episode.
- **Commit:** ignored if `cand == last`.
  - Otherwise `last <= cand`.
  - If `cand == 7'h00` (blank): nothing is pushed.
  - Otherwise a decode is pushed and `digit_count` increments.
  - A blank between two identical digits therefore makes the second one count.
- **Decode (exact patterns only):**
  - Digits 0–9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Hex A–F: 77,7C,39,5E,79,71.
  - Result: `{1'b0, nibble}`.
  - Any other non-zero pattern gives `{1'b1, 4'h0}`; it is still pushed and still counted.
- **FIFO:** show-ahead. `out_data` is the head entry whenever `out_valid` is high; otherwise it is 0.
  - Pop when `out_valid && out_ready`.
  - Push when commit is non-blank and not full, or when full and a pop occurs in the same cycle.
  - Push into full with no pop: the entry is dropped, `overflow <= 1`, `digit_count` still increments.
  - Simultaneous push and pop when empty: the push lands and `fifo_level` becomes 1.
- **`clr`:** `overflow <= 0`, `digit_count <= 0`. It does not affect the FIFO or the filter.
  - A same-cycle commit that would increment the count: `clr` wins, count = 0.
  - A same-cycle drop that would set `overflow`: `clr` wins, `overflow` = 0.
- **Reset values:** all outputs 0; `cand`, `last`, `s1`, `s`, `cnt` = 0; FIFO empty.
  - Because `last` = 0, a blank bus after reset never commits.
  - Reset asserted mid-operation discards queued entries and any partially filtered pattern immediately.

## Timing
- `out_valid` rises after the (`STABLE_CYCLES`+3)th rising edge, counting the first edge that samples a new stable `seg_in` as edge 1.
  - With the default `STABLE_CYCLES`=4 this is after edge 7.
- Glitches shorter than `STABLE_CYCLES`+1 synchronised cycles never commit.
- A pop is visible on `out_data`, `fifo_level` and `out_valid` the cycle after the accepting edge.
- Throughput is one pop per cycle. Pushes are limited by the filter to at most one per `STABLE_CYCLES`+1 cycles.
- `digit_count` and `overflow` update on the commit edge.

## Test plan
- **Single digit:** reset, then `seg_in`=7'h4F held 10 cycles with `out_ready`=0.
  - Expect `out_valid` high after edge 7 with `out_data`=5'h03, `fifo_level`=1 and `digit_count`=1.
- **Glitch rejection:** `seg_in`=7'h06 pulsed for 3 cycles, then 7'h00 held.
  - Expect no push and `digit_count`=0.
- **Repeat and blank:** 7'h06 held, then 7'h00, then 7'h06 again, each held for 8 cycles.
  - Expect two entries of 5'h01 and `digit_count`=2.
  - Holding 7'h06 for 20 cycles instead gives only one entry.
- **Invalid pattern:** `seg_in`=7'h55 held.
  - Expect `out_data`=5'h10 and `digit_count`=1.
- **Overflow:** with `out_ready`=0, apply 5 distinct digits 0,1,2,3,4.
  - Expect `fifo_level`=4, `overflow`=1 and `digit_count`=5.
  - Then pop all entries with `out_ready`=1: expect the sequence 0,1,2,3, then `out_valid`=0.
  - Then pulse `clr`: `overflow`=0 and `digit_count`=0.
- **Full push with pop, and reset mid-stream:**
  - With the FIFO full, pop in the same cycle as a commit of 7'h7F. Expect 7'h7F accepted, `fifo_level` stays 4, no overflow.
  - Assert `rst` between clock edges with the FIFO holding entries. Expect `out_valid`=0 and `fifo_level`=0 immediately.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: synchronises a glitchy seven-segment bus, accepts patterns only
// after they have held steady, decodes them to hex nibbles and queues them
// behind a show-ahead valid/ready FIFO.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    seg_in,
  input  logic                          clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    out_data,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    digit_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [6:0]    s1, s, cand, last;
  logic [CW-1:0] cnt;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic commit, commit_new, commit_digit, full, pop, push, drop;

  // Exact-match decode; anything else non-blank is flagged as an error entry.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  // Commit fires once per stable episode; repeats of the last pattern are ignored.
  always_comb begin
    commit       = (s == cand) && (cnt == CNT_FIRE);
    commit_new   = commit && (cand != last);
    commit_digit = commit_new && (cand != 7'h00);
    full         = (level == LVL_FULL);
    out_valid    = (level != '0);
    pop          = out_valid && out_ready;
    push         = commit_digit && (!full || pop);
    drop         = commit_digit && full && !pop;
    out_data     = out_valid ? mem[rd_ptr] : 5'h00;
    fifo_level   = level;
  end

  // Two-flop synchroniser for the asynchronous segment bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= seg_in;
      s  <= s1;
    end
  end

  // Stability filter: restart on any change, saturate once settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (commit_new) last <= cand;
    end
  end

  // FIFO storage and pointers; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= decode(cand);
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Status counters; clear takes priority over a same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      digit_count <= '0;
    end else if (clr) begin
      overflow    <= 1'b0;
      digit_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (commit_digit) digit_count <= digit_count + 8'd1;
    end
  end
endmodule
